// File: rtl/tc0260dar_palette_if.sv
// CPU-side bus of the tc0260dar palette: 68000-style waited access to palette RAM.
// Handshake: the master raises cs with at least one strobe low (cpu_ds_n != 2'b11) and
// holds address/data/rw until cpu_dtack_n goes low; it then drops cs or both strobes,
// and cpu_dtack_n returns high on the next clk edge. cpu_dout is valid while dtack_n is low.
interface tc0260dar_palette_if;
  logic        cs;
  logic [11:0] cpu_addr;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        cpu_rw;
  logic [1:0]  cpu_ds_n;
  logic        cpu_dtack_n;

  modport master (
    output cs, cpu_addr, cpu_din, cpu_rw, cpu_ds_n,
    input  cpu_dout, cpu_dtack_n
  );

  modport slave (
    input  cs, cpu_addr, cpu_din, cpu_rw, cpu_ds_n,
    output cpu_dout, cpu_dtack_n
  );
endinterface

// File: rtl/tc0260dar_palette.sv
// Palette/DAC stage: 4096x16 palette RAM shared by the pixel pipeline and the CPU.
// Optional macro DAR_READBACK_EN: when defined, CPU reads return RAM data; otherwise 16'hFFFF.
module tc0260dar_palette #(
  parameter int FORMAT = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce_pixel,
  tc0260dar_palette_if.slave        bus,
  input  logic [13:0]               color_in,
  input  logic                      blank_n_in,
  output logic [7:0]                red,
  output logic [7:0]                green,
  output logic [7:0]                blue,
  output logic                      blank_n_out,
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {IDLE, PEND, RDWAIT, ACK} state_t;

  state_t      state;
  logic [11:0] addr_q;
  logic [15:0] din_q;
  logic        rw_q;
  logic [1:0]  ds_q;

  logic [15:0] mem [4096];
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [15:0] pix_rd;
`ifdef DAR_READBACK_EN
  logic [15:0] cpu_rd;
`endif

  logic [15:0] pix_word;
  logic        blank_d1;
  logic        blank_d2;
  logic        unused_color;

  assign unused_color = ^color_in[13:12];
  assign state_dbg    = state;

  // Single address port: the pixel pipeline wins every ce_pixel edge.
  assign ram_addr = ce_pixel ? color_in[11:0] : addr_q;
  assign ram_we   = !reset && !ce_pixel && (state == PEND) && !rw_q;

  // Both lanes of a write commit on the same edge, so a write is never split.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      if (!ds_q[1]) mem[ram_addr][15:8] <= din_q[15:8];
      if (!ds_q[0]) mem[ram_addr][7:0]  <= din_q[7:0];
    end
    if (ce_pixel) begin
      pix_rd <= mem[ram_addr];
    end
`ifdef DAR_READBACK_EN
    else if (state == PEND && rw_q) begin
      cpu_rd <= mem[ram_addr];
    end
`endif
  end

  function automatic logic [23:0] to_rgb(input logic [15:0] w);
    if (FORMAT == 0) begin
      return {w[15:12], w[15:12], w[11:8], w[11:8], w[7:4], w[7:4]};
    end else begin
      return {w[14:10], w[14:12], w[9:5], w[9:7], w[4:0], w[4:2]};
    end
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      blank_d1    <= 1'b0;
      blank_d2    <= 1'b0;
      pix_word    <= 16'd0;
      red         <= 8'd0;
      green       <= 8'd0;
      blue        <= 8'd0;
      blank_n_out <= 1'b0;
    end else if (ce_pixel) begin
      blank_d1    <= blank_n_in;
      blank_d2    <= blank_d1;
      pix_word    <= pix_rd;
      {red, green, blue} <= blank_d2 ? to_rgb(pix_word) : 24'd0;
      blank_n_out <= blank_d2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      bus.cpu_dtack_n <= 1'b1;
      bus.cpu_dout    <= 16'd0;
      addr_q          <= 12'd0;
      din_q           <= 16'd0;
      rw_q            <= 1'b1;
      ds_q            <= 2'b11;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cs && bus.cpu_ds_n != 2'b11) begin
            addr_q <= bus.cpu_addr;
            din_q  <= bus.cpu_din;
            rw_q   <= bus.cpu_rw;
            ds_q   <= bus.cpu_ds_n;
            state  <= PEND;
          end
        end
        PEND: begin
          if (!ce_pixel) begin
            if (!rw_q) begin
              state           <= ACK;
              bus.cpu_dtack_n <= 1'b0;
            end else begin
`ifdef DAR_READBACK_EN
              state           <= RDWAIT;
`else
              bus.cpu_dout    <= 16'hFFFF;
              state           <= ACK;
              bus.cpu_dtack_n <= 1'b0;
`endif
            end
          end
        end
        RDWAIT: begin
          // The pixel path issued its address on an earlier edge, so this capture is always safe.
`ifdef DAR_READBACK_EN
          bus.cpu_dout    <= cpu_rd;
`else
          bus.cpu_dout    <= 16'hFFFF;
`endif
          state           <= ACK;
          bus.cpu_dtack_n <= 1'b0;
        end
        ACK: begin
          if (!bus.cs || bus.cpu_ds_n == 2'b11) begin
            state           <= IDLE;
            bus.cpu_dtack_n <= 1'b1;
          end
        end
        default: begin
          state           <= IDLE;
          bus.cpu_dtack_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tc0260dar_palette.sv
// Bench for tc0260dar_palette: FORMAT=0 and FORMAT=1 instances driven in lockstep,
// checked every cycle against a palette/pipeline model plus literal directed expectations.
module tb_tc0260dar_palette;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce_pixel = 1'b0;
  logic [13:0] color_in = 14'd0;
  logic        blank_n_in = 1'b0;
  logic [7:0]  red0, green0, blue0, red1, green1, blue1;
  logic        blank0, blank1;
  logic [1:0]  st0, st1;

  tc0260dar_palette_if bus0();
  tc0260dar_palette_if bus1();

  tc0260dar_palette #(.FORMAT(0)) dut0 (
    .clk(clk), .reset(reset), .ce_pixel(ce_pixel), .bus(bus0),
    .color_in(color_in), .blank_n_in(blank_n_in),
    .red(red0), .green(green0), .blue(blue0), .blank_n_out(blank0), .state_dbg(st0)
  );

  tc0260dar_palette #(.FORMAT(1)) dut1 (
    .clk(clk), .reset(reset), .ce_pixel(ce_pixel), .bus(bus1),
    .color_in(color_in), .blank_n_in(blank_n_in),
    .red(red1), .green(green1), .blue(blue1), .blank_n_out(blank1), .state_dbg(st1)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          errors = 0;
  int          checks = 0;
  bit          chk_en = 1'b0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_mem [4096];
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  logic [11:0] m_addr;
  logic [15:0] m_din;
  logic        m_rw;
  logic [1:0]  m_ds;
  logic [24:0] hist0 [2];
  logic [24:0] hist1 [2];
  logic [24:0] exp0 = 25'd0;
  logic [24:0] exp1 = 25'd0;

  // {r, g, b, blank_n} a pixel of word w must show on the outputs.
  function automatic logic [24:0] model_pix(input logic [15:0] w, input logic bl, input int fmt);
    int r, g, b;
    if (!bl) return 25'd0;
    if (fmt == 0) begin
      r = ((w >> 12) & 15) * 17;
      g = ((w >> 8) & 15) * 17;
      b = ((w >> 4) & 15) * 17;
    end else begin
      r = (w >> 10) & 31;  r = r * 8 + r / 4;
      g = (w >> 5) & 31;   g = g * 8 + g / 4;
      b = w & 31;          b = b * 8 + b / 4;
    end
    return {r[7:0], g[7:0], b[7:0], 1'b1};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      hist0[0] = 25'd0; hist0[1] = 25'd0;
      hist1[0] = 25'd0; hist1[1] = 25'd0;
      exp0 = 25'd0;
      exp1 = 25'd0;
    end else begin
      // CPU side: a pending write lands in memory on the first edge the pixel path leaves free.
      if (!m_busy) begin
        if (bus0.cs && bus0.cpu_ds_n != 2'b11) begin
          m_busy = 1'b1; m_done = 1'b0;
          m_addr = bus0.cpu_addr; m_din = bus0.cpu_din;
          m_rw = bus0.cpu_rw; m_ds = bus0.cpu_ds_n;
        end
      end else if (!m_done) begin
        if (!ce_pixel) begin
          if (!m_rw) begin
            if (!m_ds[1]) m_mem[m_addr][15:8] = m_din[15:8];
            if (!m_ds[0]) m_mem[m_addr][7:0]  = m_din[7:0];
          end
          m_done = 1'b1;
        end
      end else if (!bus0.cs || bus0.cpu_ds_n == 2'b11) begin
        m_busy = 1'b0;
      end
      // Pixel side: output on a pixel edge is what was looked up two pixel edges earlier.
      if (ce_pixel) begin
        exp0 = hist0[1]; hist0[1] = hist0[0];
        exp1 = hist1[1]; hist1[1] = hist1[0];
        hist0[0] = model_pix(m_mem[color_in[11:0]], blank_n_in, 0);
        hist1[0] = model_pix(m_mem[color_in[11:0]], blank_n_in, 1);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pix_f0", {red0, green0, blue0, blank0}, exp0);
      check("pix_f1", {red1, green1, blue1, blank1}, exp1);
    end
  end

  // ---------------- driver tasks ----------------
  int          ce_mode = 3;    // 0 manual, 1 random, 2 forced high, 3 forced low
  bit          pix_live = 1'b0;
  logic [11:0] pool [16];

  task automatic tick();
    logic [1:0] hi;
    @(negedge clk);
    case (ce_mode)
      1: ce_pixel = ($urandom_range(0, 2) == 0);
      2: ce_pixel = 1'b1;
      3: ce_pixel = 1'b0;
      default: ;
    endcase
    if (ce_mode != 0 && pix_live) begin
      hi = 2'($urandom_range(0, 3));
      color_in = {hi, pool[$urandom_range(0, 15)]};
      blank_n_in = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic drive_bus(input logic cs, input logic [11:0] a, input logic [15:0] d,
                           input logic rw, input logic [1:0] ds);
    bus0.cs = cs; bus0.cpu_addr = a; bus0.cpu_din = d; bus0.cpu_rw = rw; bus0.cpu_ds_n = ds;
    bus1.cs = cs; bus1.cpu_addr = a; bus1.cpu_din = d; bus1.cpu_rw = rw; bus1.cpu_ds_n = ds;
  endtask

  task automatic cpu_req(input logic [11:0] a, input logic [15:0] d, input logic rw,
                         input logic [1:0] ds, output int lat);
    logic [15:0] exp_rd;
    if (rw) begin
`ifdef DAR_READBACK_EN
      exp_q.push_back(m_mem[a]);
`else
      exp_q.push_back(16'hFFFF);
`endif
    end
    drive_bus(1'b1, a, d, rw, ds);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (bus0.cpu_dtack_n && lat < 200);
    if (bus0.cpu_dtack_n) begin
      checks++;
      errors++;
      $display("FAIL dtack_timeout: dtack_n=1 after %0d clk, required 0 (addr %h)", lat, a);
    end
    check("dtack_f1", bus1.cpu_dtack_n, 1'b0);
    if (rw) begin
      exp_rd = exp_q.pop_front();
      check("rd_f0", bus0.cpu_dout, exp_rd);
      check("rd_f1", bus1.cpu_dout, exp_rd);
    end
    drive_bus(1'b0, a, d, 1'b1, 2'b11);
    tick();
    check("dtack_release", bus0.cpu_dtack_n, 1'b1);
  endtask

  // Pixel idx enters on edge E0; outputs sampled right after E2.
  task automatic probe(input logic [11:0] idx, input logic bl,
                       output logic [24:0] o0, output logic [24:0] o1);
    ce_mode = 0;
    tick(); ce_pixel = 1'b1; color_in = {2'b11, idx}; blank_n_in = bl;
    tick(); ce_pixel = 1'b0; color_in = 14'd0; blank_n_in = 1'b0;
    tick(); ce_pixel = 1'b1;
    tick(); ce_pixel = 1'b0;
    tick(); ce_pixel = 1'b1;
    tick(); ce_pixel = 1'b0;
    o0 = {red0, green0, blue0, blank0};
    o1 = {red1, green1, blue1, blank1};
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          lat;
    int          k;
    logic [1:0]  ds;
    logic        rw;
    logic [24:0] o0, o1;

    drive_bus(1'b0, 12'd0, 16'd0, 1'b1, 2'b11);
    pool[0] = 12'h123; pool[1] = 12'h001; pool[2] = 12'h0A0;
    for (int i = 3; i < 16; i++) pool[i] = 12'($urandom_range(0, 4095));

    ce_mode = 3;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk_en = 1'b1;
    check("rst_rgb", {red0, green0, blue0, blank0}, 25'd0);
    check("rst_dtack", bus0.cpu_dtack_n, 1'b1);
    check("rst_state", st0, 2'd0);
    check("rst_dout", bus0.cpu_dout, 16'd0);

    // Full-word write and minimum latencies with the pixel path idle.
    cpu_req(12'h123, 16'hF0A0, 1'b0, 2'b00, lat);
    check("wr_latency", lat, 2);
    cpu_req(12'h123, 16'h0000, 1'b1, 2'b00, lat);
`ifdef DAR_READBACK_EN
    check("rd_latency", lat, 3);
`else
    check("rd_latency", lat, 2);
`endif
    probe(12'h123, 1'b1, o0, o1);
    check("f0_F0A0", o0, {24'hFF00AA, 1'b1});
    check("f1_F0A0", o1, {24'hE72900, 1'b1});

    // Lower-lane byte write onto FFFF.
    cpu_req(12'h001, 16'hFFFF, 1'b0, 2'b00, lat);
    cpu_req(12'h001, 16'h1234, 1'b0, 2'b10, lat);
    cpu_req(12'h001, 16'h0000, 1'b1, 2'b00, lat);
    probe(12'h001, 1'b1, o0, o1);
    check("f0_FF34", o0, {24'hFFFF33, 1'b1});

    probe(12'h123, 1'b0, o0, o1);
    check("blank_f0", o0, 25'd0);
    check("blank_f1", o1, 25'd0);

    cpu_req(12'h0A0, 16'h7FFF, 1'b0, 2'b00, lat);
    probe(12'h0A0, 1'b1, o0, o1);
    check("f1_7FFF", o1, {24'hFFFFFF, 1'b1});
    cpu_req(12'h0A0, 16'h4210, 1'b0, 2'b00, lat);
    probe(12'h0A0, 1'b1, o0, o1);
    check("f1_4210", o1, {24'h848484, 1'b1});

    // Stall: pixel clock enable held high with a write pending.
    ce_mode = 2;
    tick();
    drive_bus(1'b1, 12'h0A0, 16'h5A5A, 1'b0, 2'b00);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("stall_dtack", bus0.cpu_dtack_n, 1'b1);
    end
    ce_mode = 3;
    ce_pixel = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (bus0.cpu_dtack_n && lat < 2);
    check("stall_release", bus0.cpu_dtack_n, 1'b0);
    drive_bus(1'b0, 12'h0A0, 16'h5A5A, 1'b1, 2'b11);
    tick();
    probe(12'h0A0, 1'b1, o0, o1);
    check("stall_commit_f0", o0, {24'h55AA55, 1'b1});

    // Reset while a write sits in PEND.
    ce_mode = 2;
    tick();
    drive_bus(1'b1, 12'h123, 16'h0000, 1'b0, 2'b00);
    repeat (3) tick();
    reset = 1'b1;
    drive_bus(1'b0, 12'h123, 16'h0000, 1'b1, 2'b11);
    tick();
    check("rstmid_dtack", bus0.cpu_dtack_n, 1'b1);
    check("rstmid_state", st0, 2'd0);
    reset = 1'b0;
    ce_mode = 3;
    ce_pixel = 1'b0;
    tick();
    probe(12'h123, 1'b1, o0, o1);
    check("rstmid_word_f0", o0, {24'hFF00AA, 1'b1});
    cpu_req(12'h123, 16'h0000, 1'b1, 2'b00, lat);

    // Fill the rest of the pool, then random traffic on both sides.
    ce_mode = 3;
    for (int i = 3; i < 16; i++) cpu_req(pool[i], 16'($urandom), 1'b0, 2'b00, lat);
    ce_mode = 1;
    pix_live = 1'b1;
    for (int n = 0; n < 80; n++) begin
      k  = $urandom_range(0, 2);
      ds = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b10;
      rw = 1'($urandom_range(0, 1));
      cpu_req(pool[$urandom_range(0, 15)], 16'($urandom), rw, ds, lat);
      repeat ($urandom_range(0, 5)) tick();
    end
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
